// File: rtl/mmc1_mapper_if.sv
// CPU/PPU bus bundle between the cart wrapper and the MMC1 mapper core.
// The master drives bus addresses and data; the slave (mapper) returns memory addresses and enables.
interface mmc1_mapper_if #(
    parameter int PRG_ADDR_W = 18,
    parameter int CHR_ADDR_W = 17
);
    logic [14:0]           cpu_addr;
    logic [7:0]            cpu_data_i;
    logic                  cpu_rw;
    logic                  romsel;
    logic [PRG_ADDR_W-1:0] prg_addr;
    logic                  prgram_ce;
    logic [13:0]           ppu_addr;
    logic [CHR_ADDR_W-1:0] chr_addr;
    logic                  ciram_ce;
    logic                  ciram_a10;

    modport master (
        output cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr,
        input  prg_addr, prgram_ce, chr_addr, ciram_ce, ciram_a10
    );

    modport slave (
        input  cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr,
        output prg_addr, prgram_ce, chr_addr, ciram_ce, ciram_a10
    );
endinterface

// File: rtl/mmc1_mapper.sv
// MMC1 (iNES mapper 1) core: serial register loading, PRG/CHR banking and mirroring.
// Address outputs are combinational; register updates land one cycle after the accepting edge.
module mmc1_mapper #(
    parameter int PRG_ADDR_W = 18,
    parameter int CHR_ADDR_W = 17,
    parameter int PRG_RAM_EN = 1
) (
    input  logic          clk_cpu,
    input  logic          rst,
    mmc1_mapper_if.slave  bus
);
    logic       w_wr;
    logic       w_accept;
    logic [4:0] w_shift;
    logic       r_wr_q;
    logic [4:0] r_sr;
    logic [4:0] r_ctrl;
    logic [4:0] r_chr0;
    logic [4:0] r_chr1;
    logic [4:0] r_prg;
    logic [3:0] w_bank;
    logic [17:0] w_prg_full;
    logic [16:0] w_chr_full;
    logic       w_a10;

    assign w_wr     = !bus.romsel && !bus.cpu_rw;
    // Only the first cycle of a write run counts, which drops RMW dummy writes.
    assign w_accept = w_wr && !r_wr_q;
    assign w_shift  = {bus.cpu_data_i[0], r_sr[4:1]};

    always_ff @(posedge clk_cpu) begin
        if (!rst) begin
            r_wr_q <= 1'b0;
            r_sr   <= 5'b10000;
            r_ctrl <= 5'h0C;
            r_chr0 <= 5'h00;
            r_chr1 <= 5'h00;
            r_prg  <= 5'h00;
        end else begin
            r_wr_q <= w_wr;
            if (w_accept) begin
                if (bus.cpu_data_i[7]) begin
                    r_sr   <= 5'b10000;
                    r_ctrl <= r_ctrl | 5'h0C;
                end else if (!r_sr[0]) begin
                    r_sr <= w_shift;
                end else begin
                    r_sr <= 5'b10000;
                    unique case (bus.cpu_addr[14:13])
                        2'b00: r_ctrl <= w_shift;
                        2'b01: r_chr0 <= w_shift;
                        2'b10: r_chr1 <= w_shift;
                        2'b11: r_prg  <= w_shift;
                    endcase
                end
            end
        end
    end

    // All-ones bank is the last 16K bank once truncated to the bank field.
    always_comb begin
        w_bank = 4'h0;
        unique case (r_ctrl[3:2])
            2'b10:   w_bank = bus.cpu_addr[14] ? r_prg[3:0] : 4'h0;
            2'b11:   w_bank = bus.cpu_addr[14] ? 4'hF : r_prg[3:0];
            default: w_bank = {r_prg[3:1], bus.cpu_addr[14]};
        endcase
    end

    assign w_prg_full   = {w_bank, bus.cpu_addr[13:0]};
    assign bus.prg_addr = w_prg_full[PRG_ADDR_W-1:0];

    assign bus.prgram_ce = (PRG_RAM_EN != 0) && !r_prg[4] && bus.romsel &&
                           (bus.cpu_addr[14:13] == 2'b11);

    always_comb begin
        w_chr_full = {r_chr0[4:1], bus.ppu_addr[12:0]};
        if (r_ctrl[4]) begin
            w_chr_full = {(bus.ppu_addr[12] ? r_chr1 : r_chr0), bus.ppu_addr[11:0]};
        end
    end

    assign bus.chr_addr = w_chr_full[CHR_ADDR_W-1:0];

    always_comb begin
        w_a10 = 1'b0;
        unique case (r_ctrl[1:0])
            2'b00: w_a10 = 1'b0;
            2'b01: w_a10 = 1'b1;
            2'b10: w_a10 = bus.ppu_addr[10];
            2'b11: w_a10 = bus.ppu_addr[11];
        endcase
    end

    assign bus.ciram_a10 = w_a10;
    assign bus.ciram_ce  = ~bus.ppu_addr[13];
endmodule
